// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: activation/conv-sum widths, map defaults,
// and the saturating ReLU used by every requantization stage.
package cnn_pkg;

   localparam int unsigned ACT_W      = 9;
   localparam int unsigned CONV_SUM_W = 26;
   localparam int unsigned BIAS_W     = 16;
   localparam int unsigned ACT_MAX    = 255;
   localparam int unsigned REQ_SHIFT  = 8;
   localparam int unsigned FMAP_W_DEF = 24;
   localparam int unsigned FMAP_H_DEF = 24;

   // Clamp a signed value into 0..max_val (ReLU followed by upper saturation).
   function automatic logic [31:0] sat_relu(input logic signed [63:0] r,
                                            input logic [31:0] max_val);
      if (r < 0) begin
         return '0;
      end
      if (r > $signed({32'd0, max_val})) begin
         return max_val;
      end
      return r[31:0];
   endfunction

endpackage

// File: rtl/requant_relu.sv
// Stage Q: bias add, round-half-up arithmetic shift, ReLU and saturation, registered.
// The result is non-negative, so only the magnitude bits (OUT_W-1) are carried out.
module requant_relu #(
   parameter int unsigned IN_W   = cnn_pkg::CONV_SUM_W,
   parameter int unsigned BIAS_W = cnn_pkg::BIAS_W,
   parameter int unsigned OUT_W  = cnn_pkg::ACT_W,
   parameter int unsigned SHIFT  = cnn_pkg::REQ_SHIFT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic signed [IN_W-1:0]  in_data,
   input  logic signed [BIAS_W-1:0] bias,
   output logic                    q_valid,
   output logic [OUT_W-2:0]        q_data
);
   import cnn_pkg::*;

   // Two guard bits: one for the bias add, one for the rounding constant.
   localparam int unsigned SW = IN_W + 2;
   localparam int unsigned MW = OUT_W - 1;
   localparam logic signed [SW-1:0] HALF = {{(SW-1){1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic [31:0] Q_MAX = (32'd1 << (OUT_W - 1)) - 32'd1;

   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] rnd;
   logic [MW-1:0]        q_d;

   always_comb begin
      sum = SW'(in_data) + SW'(bias);
      rnd = (sum + HALF) >>> SHIFT;
      q_d = MW'(sat_relu(64'(rnd), Q_MAX));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_valid <= 1'b0;
         q_data  <= '0;
      end else begin
         q_valid <= in_valid;
         if (in_valid) begin
            q_data <= q_d;
         end
      end
   end

endmodule

// File: rtl/relu_maxpool_stage.sv
// Requantize/ReLU each conv sum, then 2x2 stride-2 max pool the raster-ordered map.
// Even rows park pair maxima in a row buffer; odd rows combine them and emit.
module relu_maxpool_stage #(
   parameter int unsigned IN_W   = cnn_pkg::CONV_SUM_W,
   parameter int unsigned BIAS_W = cnn_pkg::BIAS_W,
   parameter int unsigned OUT_W  = cnn_pkg::ACT_W,
   parameter int unsigned SHIFT  = cnn_pkg::REQ_SHIFT,
   parameter int unsigned FMAP_W = cnn_pkg::FMAP_W_DEF,
   parameter int unsigned FMAP_H = cnn_pkg::FMAP_H_DEF,
   localparam int unsigned PRW = (FMAP_H / 2 > 1) ? $clog2(FMAP_H / 2) : 1,
   localparam int unsigned PCW = (FMAP_W / 2 > 1) ? $clog2(FMAP_W / 2) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     frame_start,
   input  logic                     in_valid,
   input  logic signed [IN_W-1:0]   in_data,
   input  logic signed [BIAS_W-1:0] bias,
   output logic                     out_valid,
   output logic [OUT_W-1:0]         out_data,
   output logic [PRW-1:0]           out_row,
   output logic [PCW-1:0]           out_col,
   output logic                     frame_done
);
   import cnn_pkg::*;

   // Counter LSB selects pair position; the upper bits are the pooled index.
   localparam int unsigned RW = PRW + 1;
   localparam int unsigned CW = PCW + 1;
   localparam int unsigned MW = OUT_W - 1;
   localparam int unsigned BW = FMAP_W / 2;
   localparam logic [RW-1:0] ROW_LAST = RW'(FMAP_H - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(FMAP_W - 1);

   logic [RW-1:0] row_q, row_d, cur_row, qrow_q;
   logic [CW-1:0] col_q, col_d, cur_col, qcol_q;

   logic          q_valid;
   logic [MW-1:0] q_data;

   logic [MW-1:0]  hold_q;
   logic [MW-1:0]  rowbuf [BW];
   logic [PCW-1:0] rb_idx;
   logic [MW-1:0]  pair_max, rb_val, pooled;
   logic           p_fire;

   // Input raster counters; frame_start forces the current sample to (0,0).
   always_comb begin
      cur_row = frame_start ? '0 : row_q;
      cur_col = frame_start ? '0 : col_q;
      row_d   = cur_row;
      col_d   = cur_col;
      if (in_valid) begin
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
         end else begin
            col_d = cur_col + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_q  <= '0;
         col_q  <= '0;
         qrow_q <= '0;
         qcol_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
         if (in_valid) begin
            qrow_q <= cur_row;
            qcol_q <= cur_col;
         end
      end
   end

   requant_relu #(
      .IN_W  (IN_W),
      .BIAS_W(BIAS_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_requant (
      .clk     (clk),
      .reset   (reset),
      .in_valid(in_valid),
      .in_data (in_data),
      .bias    (bias),
      .q_valid (q_valid),
      .q_data  (q_data)
   );

   // A sample still sitting in Q when frame_start arrives belongs to the old frame.
   always_comb begin
      p_fire   = q_valid && !frame_start;
      rb_idx   = qcol_q[PCW:1];
      pair_max = (hold_q > q_data) ? hold_q : q_data;
      rb_val   = rowbuf[rb_idx];
      pooled   = (rb_val > pair_max) ? rb_val : pair_max;
   end

   always_ff @(posedge clk) begin
      if (p_fire && qcol_q[0] && !qrow_q[0]) begin
         rowbuf[rb_idx] <= pair_max;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q     <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_row    <= '0;
         out_col    <= '0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (p_fire) begin
            if (!qcol_q[0]) begin
               hold_q <= q_data;
            end else if (qrow_q[0]) begin
               out_valid  <= 1'b1;
               out_data   <= {1'b0, pooled};
               out_row    <= qrow_q[PRW:1];
               out_col    <= qcol_q[PCW:1];
               frame_done <= (qrow_q == ROW_LAST) && (qcol_q == COL_LAST);
            end
         end
      end
   end

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// Directed bench for relu_maxpool_stage on a 4x4 map: a window-level reference model
// predicts every pooled output and its due cycle; literal checks pin the model.
module tb_relu_maxpool_stage;

   localparam int IN_W   = 26;
   localparam int BIAS_W = 16;
   localparam int OUT_W  = 9;
   localparam int SHIFT  = 8;
   localparam int FW     = 4;
   localparam int FH     = 4;
   localparam int NPIX   = FW * FH;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     frame_start;
   logic                     in_valid;
   logic signed [IN_W-1:0]   in_data;
   logic signed [BIAS_W-1:0] bias;
   logic                     out_valid;
   logic [OUT_W-1:0]         out_data;
   logic [0:0]               out_row;
   logic [0:0]               out_col;
   logic                     frame_done;

   relu_maxpool_stage #(
      .IN_W  (IN_W),
      .BIAS_W(BIAS_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT),
      .FMAP_W(FW),
      .FMAP_H(FH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_start(frame_start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .bias       (bias),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_row    (out_row),
      .out_col    (out_col),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   typedef struct {
      longint data;
      int     row;
      int     col;
      bit     last;
      int     due;
   } exp_t;

   exp_t   exp_q[$];
   longint cap[$];
   longint model_vals[NPIX];
   int     pos = 0;
   longint cur_bias = 0;
   bit     mon_on = 0;
   int     checks = 0;
   int     failures = 0;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cycle);
      end
   endtask

   // Reference requantization from the arithmetic definition (floor division).
   function automatic longint requant(input longint x, input longint b);
      longint s, d, r;
      d = longint'(1) << SHIFT;
      s = x + b + (d / 2);
      if (s >= 0) r = s / d;
      else        r = -((-s + d - 1) / d);
      if (r < 0) r = 0;
      if (r > 255) r = 255;
      return r;
   endfunction

   function automatic longint max2(input longint a, input longint b);
      return (a > b) ? a : b;
   endfunction

   // Drop predictions that can no longer appear after a flush at this cycle.
   task automatic flush_pending();
      exp_t keep[$];
      foreach (exp_q[i]) if (exp_q[i].due <= cycle) keep.push_back(exp_q[i]);
      exp_q = keep;
   endtask

   task automatic send(input longint x, input bit fs);
      int r, c;
      exp_t e;
      @(negedge clk);
      if (fs) begin
         flush_pending();
         pos = 0;
      end
      frame_start = fs;
      in_valid    = 1'b1;
      in_data     = IN_W'(x);
      r = pos / FW;
      c = pos % FW;
      model_vals[pos] = requant(x, cur_bias);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
         e.data = max2(max2(model_vals[(r-1)*FW + c-1], model_vals[(r-1)*FW + c]),
                       max2(model_vals[r*FW + c-1], model_vals[r*FW + c]));
         e.row  = r / 2;
         e.col  = c / 2;
         e.last = (pos == NPIX - 1);
         e.due  = cycle + 2;
         exp_q.push_back(e);
      end
      pos = (pos + 1) % NPIX;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      in_valid    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input longint v[NPIX], input int max_gap, input bit fs_first);
      for (int i = 0; i < NPIX; i++) begin
         send(v[i], fs_first && (i == 0));
         if (max_gap > 0) idle($urandom_range(0, max_gap));
      end
      idle(6);
   endtask

   // Frame whose 2x2 windows are each filled with one value.
   task automatic uniform_frame(input longint w[4], output longint v[NPIX]);
      for (int i = 0; i < NPIX; i++) v[i] = w[((i / FW) / 2) * 2 + (i % FW) / 2];
   endtask

   task automatic check_cap(input string name, input longint lit[4]);
      check({name, "_count"}, cap.size(), 4);
      for (int i = 0; i < 4 && i < cap.size(); i++) check(name, cap[i], lit[i]);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      flush_pending();
      pos   = 0;
      reset = 1'b1;
      repeat (n) begin
         @(negedge clk);
         check("reset_out_valid", out_valid, 0);
         check("reset_out_data", out_data, 0);
         check("reset_out_row", out_row, 0);
         check("reset_out_col", out_col, 0);
         check("reset_frame_done", frame_done, 0);
      end
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_on) begin
         if (out_valid) begin
            cap.push_back(longint'(out_data));
            if (exp_q.size() == 0) begin
               check("spurious_out_valid", out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_data", out_data, e.data);
               check("out_row", out_row, e.row);
               check("out_col", out_col, e.col);
               check("frame_done", frame_done, e.last);
               check("out_latency", cycle, e.due);
            end
         end else begin
            check("frame_done_idle", frame_done, 0);
            if (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
               check("missing_out_valid", out_valid, 1);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint w[4];
      longint v[NPIX];
      longint ramp[NPIX];
      longint lit[4];

      reset = 1'b1; frame_start = 1'b0; in_valid = 1'b0; in_data = '0; bias = '0;
      for (int i = 0; i < NPIX; i++) ramp[i] = longint'(i + 1) * 256;
      repeat (3) @(negedge clk);
      check("init_out_valid", out_valid, 0);
      check("init_out_data", out_data, 0);
      check("init_out_row", out_row, 0);
      check("init_out_col", out_col, 0);
      check("init_frame_done", frame_done, 0);
      reset  = 1'b0;
      mon_on = 1'b1;

      // Requant basics with bias 0: 1000->4, -500->0, 100000->255.
      cap.delete();
      w = '{1000, -500, 100000, 0};
      uniform_frame(w, v);
      send_frame(v, 0, 0);
      lit = '{4, 0, 255, 0};
      check_cap("requant_bias0", lit);

      // Rounding with bias -256: 384->1, 383->0, large negative->0, 640->2.
      @(negedge clk);
      bias = -16'sd256;
      cur_bias = -256;
      cap.delete();
      w = '{384, 383, -1000000, 640};
      uniform_frame(w, v);
      send_frame(v, 0, 0);
      lit = '{1, 0, 0, 2};
      check_cap("requant_round", lit);

      // Ramp frame back-to-back, then with random gaps.
      @(negedge clk);
      bias = '0;
      cur_bias = 0;
      lit = '{6, 8, 14, 16};
      cap.delete();
      send_frame(ramp, 0, 0);
      check_cap("pool_b2b", lit);
      cap.delete();
      send_frame(ramp, 5, 0);
      check_cap("pool_gaps", lit);

      // frame_start with in_valid after 6 samples of a stale frame.
      cap.delete();
      for (int i = 0; i < 6; i++) send(200 * 256, 0);
      send_frame(ramp, 0, 1);
      check_cap("frame_restart", lit);

      // Reset at sample 10, then a fresh full frame.
      for (int i = 0; i < 10; i++) send(50 * 256, 0);
      do_reset(3);
      cap.delete();
      send_frame(ramp, 0, 0);
      check_cap("after_reset", lit);

      idle(4);
      check("pending_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
